// File: rtl/freq_meter_pkg.sv
// Shared state encoding and default sizing for the frequency meter.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_GATE_CYCLES = 50000000;
  localparam int DEF_CNT_W       = 32;

endpackage

// File: rtl/freq_meter_if.sv
// Control and result bundle of the frequency meter.
interface freq_meter_if
  import freq_meter_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);
  logic             i_sig;
  logic             i_en;
  logic [CNT_W-1:0] o_freq;
  logic             o_valid;
  logic             o_ovf;
  logic             o_busy;

  modport master (output i_sig, i_en, input o_freq, o_valid, o_ovf, o_busy);
  modport slave  (input i_sig, i_en, output o_freq, o_valid, o_ovf, o_busy);
endinterface

// File: rtl/freq_meter_sig_sync.sv
// Synchronizer chain for an asynchronous input followed by a rising-edge pulse.
module sig_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_pulse
);
  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_sync[0] <= 1'b0;
    else       r_sync[0] <= i_sig;
  end

  for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_sync[gi] <= 1'b0;
      else       r_sync[gi] <= r_sync[gi-1];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_prev <= 1'b0;
    else       r_prev <= r_sync[STAGES-1];
  end

  assign o_pulse = r_sync[STAGES-1] & ~r_prev;
endmodule

// File: rtl/freq_meter.sv
// Gated edge counter: counts rising edges of an asynchronous signal over a
// fixed window of clock cycles and publishes the count once per window.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  freq_meter_if.slave  bus
);
  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  state_t           r_state;
  logic [GW-1:0]    r_gate_cnt;
  logic [CNT_W-1:0] r_edge_cnt;
  logic             r_ovf_flag;
  logic [CNT_W-1:0] r_freq;
  logic             r_valid;
  logic             r_ovf;
  logic             r_busy;
  logic             w_pulse;
  logic [CNT_W-1:0] w_edge_next;
  logic             w_ovf_next;

  sig_sync #(.STAGES(2)) u_sig_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_sig   (bus.i_sig),
    .o_pulse (w_pulse)
  );

  // Saturating increment; the flag records that an edge was lost.
  always_comb begin
    w_edge_next = r_edge_cnt;
    w_ovf_next  = r_ovf_flag;
    if (w_pulse) begin
      if (&r_edge_cnt) w_ovf_next  = 1'b1;
      else             w_edge_next = r_edge_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_ovf_flag <= 1'b0;
      r_freq     <= '0;
      r_valid    <= 1'b0;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.i_en) begin
            r_state    <= GATE;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf_flag <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        GATE: begin
          if (!bus.i_en) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_edge_cnt <= w_edge_next;
            r_ovf_flag <= w_ovf_next;
            // Result registers load on the edge into DONE so they are seen during DONE.
            if (r_gate_cnt == GATE_LAST) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_freq  <= w_edge_next;
              r_ovf   <= w_ovf_next;
              r_valid <= 1'b1;
            end else begin
              r_gate_cnt <= r_gate_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.i_en) begin
            r_state    <= GATE;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf_flag <= 1'b0;
            r_busy     <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_freq  = r_freq;
  assign bus.o_valid = r_valid;
  assign bus.o_ovf   = r_ovf;
  assign bus.o_busy  = r_busy;
endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench: main process pushes expected window results, per-DUT
// monitors pop and compare on every o_valid.
module tb_freq_meter;
  typedef struct packed {
    logic [31:0] freq;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sig;
  int   half = 0;
  logic lvl  = 1'b0;
  int   gcnt;
  int   total = 0;
  int   passed = 0;
  exp_t qa[$];
  exp_t qb[$];

  freq_meter_if #(.CNT_W(32)) bus_a ();
  freq_meter_if #(.CNT_W(4))  bus_b ();

  assign bus_a.i_sig = sig;
  assign bus_b.i_sig = sig;

  freq_meter #(.GATE_CYCLES(100), .CNT_W(32)) u_dut_a (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_a)
  );

  freq_meter #(.GATE_CYCLES(100), .CNT_W(4)) u_dut_b (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) begin
      passed++;
      $display("ok   %-16s got=%0d", name, act);
    end else begin
      $display("FAIL %-16s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int which, input int budget, output int cycles);
    bit got;
    got = 0;
    cycles = 0;
    while (!got && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if ((which == 0) ? bus_a.o_valid : bus_b.o_valid) got = 1;
    end
    if (!got) begin
      total++;
      $display("FAIL valid_timeout dut=%0d got=none want=valid within %0d", which, budget);
    end
  endtask

  task automatic push_a(input int f, input logic o);
    exp_t e;
    e.freq = f;
    e.ovf  = o;
    qa.push_back(e);
  endtask

  task automatic push_b(input int f, input logic o);
    exp_t e;
    e.freq = f;
    e.ovf  = o;
    qb.push_back(e);
  endtask

  // Signal generator: square wave of half-period 'half', or static level 'lvl'.
  initial begin
    sig  = 1'b0;
    gcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (half == 0) begin
        sig  = lvl;
        gcnt = 0;
      end else if (gcnt >= half - 1) begin
        sig  = ~sig;
        gcnt = 0;
      end else begin
        gcnt++;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus_a.o_valid === 1'b1) begin
        if (qa.size() == 0) begin
          total++;
          $display("FAIL unexpected_valid_a got=valid freq=%0d want=no valid", bus_a.o_freq);
        end else begin
          e = qa.pop_front();
          check("freq_a", 64'(bus_a.o_freq), 64'(e.freq));
          check("ovf_a", 64'(bus_a.o_ovf), 64'(e.ovf));
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus_b.o_valid === 1'b1) begin
        if (qb.size() == 0) begin
          total++;
          $display("FAIL unexpected_valid_b got=valid freq=%0d want=no valid", bus_b.o_freq);
        end else begin
          e = qb.pop_front();
          check("freq_b", 64'(bus_b.o_freq), 64'(e.freq));
          check("ovf_b", 64'(bus_b.o_ovf), 64'(e.ovf));
        end
      end
    end
  end

  initial begin
    int c;
    bus_a.i_en = 1'b0;
    bus_b.i_en = 1'b0;
    wait_neg(3);
    check("rst_freq", 64'(bus_a.o_freq), 64'd0);
    check("rst_valid", 64'(bus_a.o_valid), 64'd0);
    check("rst_ovf", 64'(bus_a.o_ovf), 64'd0);
    check("rst_busy", 64'(bus_a.o_busy), 64'd0);
    check("rst_freq_b", 64'(bus_b.o_freq), 64'd0);
    check("rst_busy_b", 64'(bus_b.o_busy), 64'd0);
    rst = 1'b0;

    // Period-10 square wave, back-to-back windows.
    half = 5;
    wait_neg(30);
    for (int i = 0; i < 3; i++) push_a(10, 1'b0);
    bus_a.i_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_valid(0, 300, c);
      check("interval", 64'(c), 64'd101);
      check("busy_in_done", 64'(bus_a.o_busy), 64'd0);
    end
    bus_a.i_en = 1'b0;

    // Constant-high input produces no edges.
    half = 0;
    lvl  = 1'b1;
    wait_neg(10);
    push_a(0, 1'b0);
    push_a(0, 1'b0);
    bus_a.i_en = 1'b1;
    wait_valid(0, 300, c);
    wait_valid(0, 300, c);
    bus_a.i_en = 1'b0;

    // Abort at GATE cycle 50 of the second window.
    lvl  = 1'b0;
    half = 5;
    wait_neg(10);
    push_a(10, 1'b0);
    bus_a.i_en = 1'b1;
    wait_valid(0, 300, c);
    wait_neg(50);
    check("busy_mid_gate", 64'(bus_a.o_busy), 64'd1);
    bus_a.i_en = 1'b0;
    wait_neg(1);
    check("busy_after_abort", 64'(bus_a.o_busy), 64'd0);
    check("freq_after_abort", 64'(bus_a.o_freq), 64'd10);
    wait_neg(150);
    check("freq_retained", 64'(bus_a.o_freq), 64'd10);

    // Reset mid-window.
    bus_a.i_en = 1'b1;
    wait_neg(41);
    check("busy_pre_rst", 64'(bus_a.o_busy), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_freq", 64'(bus_a.o_freq), 64'd0);
    check("rst_mid_valid", 64'(bus_a.o_valid), 64'd0);
    check("rst_mid_ovf", 64'(bus_a.o_ovf), 64'd0);
    check("rst_mid_busy", 64'(bus_a.o_busy), 64'd0);
    half = 0;
    lvl  = 1'b0;
    wait_neg(3);
    push_a(10, 1'b0);
    half = 5;
    rst  = 1'b0;
    wait_valid(0, 300, c);
    check("rst_interval", 64'(c), 64'd101);
    bus_a.i_en = 1'b0;

    // Single edge landing on the last GATE cycle, then one cycle later.
    half = 0;
    lvl  = 1'b0;
    wait_neg(10);
    push_a(1, 1'b0);
    bus_a.i_en = 1'b1;
    wait_neg(97);
    lvl = 1'b1;
    wait_valid(0, 200, c);
    bus_a.i_en = 1'b0;
    lvl = 1'b0;
    wait_neg(10);
    push_a(0, 1'b0);
    bus_a.i_en = 1'b1;
    wait_neg(98);
    lvl = 1'b1;
    wait_valid(0, 200, c);
    bus_a.i_en = 1'b0;
    lvl = 1'b0;
    wait_neg(10);

    // Narrow counter: saturation, then a countable rate.
    half = 2;
    wait_neg(20);
    push_b(15, 1'b1);
    bus_b.i_en = 1'b1;
    wait_valid(1, 300, c);
    bus_b.i_en = 1'b0;
    half = 10;
    wait_neg(40);
    push_b(5, 1'b0);
    bus_b.i_en = 1'b1;
    wait_valid(1, 300, c);
    bus_b.i_en = 1'b0;
    wait_neg(5);

    check("queue_a_empty", 64'(qa.size()), 64'd0);
    check("queue_b_empty", 64'(qb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 Parameter GATE_CYCLES, default 50000000; number of I_CLK cycles in one measurement window (1 s at 50 MHz).
REQ-002 Parameter CNT_W, default 32; width of the edge counter and the O_FREQ result.
REQ-003 I_CLK  input  1  single system clock; all state updates on its rising edge.
REQ-004 Rst  input  1  asynchronous, active-high reset.
REQ-005 I_SIG  input  1  signal to be measured; asynchronous to I_CLK.
REQ-006 I_EN  input  1  level; 1 runs back-to-back measurements, 0 stops them.
REQ-007 O_FREQ  output  CNT_W  rising-edge count of I_SIG in the last completed window (Hz when the window is 1 s).
REQ-008 O_VALID  output  1  one-cycle pulse when O_FREQ is updated.
REQ-009 O_OVF  output  1  edge count saturated in the last completed window; updated together with O_FREQ.
REQ-010 O_BUSY  output  1  high while a window is open.

Function
REQ-011 I_SIG shall pass through a 2-flop synchronizer, then a 1-flop edge detector; one detected rising edge = one-cycle internal pulse, 3 cycles after the I_SIG transition.
REQ-012 FSM states: IDLE, GATE, DONE; IDLE -> GATE when I_EN=1; GATE -> DONE after exactly GATE_CYCLES cycles in GATE; DONE -> GATE if I_EN=1 else IDLE, with DONE lasting one cycle.
REQ-013 On entry to GATE, the gate counter and the edge counter shall both be cleared to 0.
REQ-014 An edge pulse is counted iff it occurs in a GATE cycle, including the first and the last GATE cycle; edges in IDLE/DONE are ignored.
REQ-015 Edge counter shall saturate at 2^CNT_W-1 and set an internal overflow flag; no wrap-around.
REQ-016 In DONE: O_FREQ <= edge count, O_OVF <= overflow flag, O_VALID = 1 for that cycle only.
REQ-017 O_BUSY = 1 exactly in GATE cycles.
REQ-018 I_EN falling to 0 during GATE shall abort the window: next state IDLE, no O_VALID; O_FREQ/O_OVF retain their previous values.
REQ-019 Back-to-back windows: DONE-to-GATE re-clears the counters, so the dead time between windows is exactly 1 cycle.
REQ-020 O_FREQ and O_OVF change only in DONE or on reset.

Reset
REQ-021 Rst=1 shall immediately force state IDLE, all counters and synchronizer flops 0, O_FREQ=0, O_VALID=0, O_OVF=0, O_BUSY=0.
REQ-022 Rst asserted mid-window shall discard the partial count; after Rst deasserts, a new window starts only on the next cycle with I_EN=1.

Structure
REQ-023 Package freq_meter_pkg shall hold the state encoding (IDLE/GATE/DONE) and the default GATE_CYCLES/CNT_W constants.
REQ-024 Sub-module sig_sync (2-flop synchronizer + rising-edge pulse, same clock/reset) shall be instantiated once; the FSM and counters stay in freq_meter.

Verification (bench uses GATE_CYCLES=100, CNT_W=32 unless stated)
REQ-025 I_EN=1, I_SIG square wave with period 10 cycles, started well before the window -> O_VALID pulse every 101 cycles, O_FREQ=10, O_OVF=0.
REQ-026 I_EN=1, I_SIG held constant at 1 -> O_FREQ=0 on every O_VALID.
REQ-027 CNT_W=4, I_SIG with period 4 cycles (25 edges per window) -> O_FREQ=15, O_OVF=1; then a period-20 signal -> O_FREQ=5, O_OVF=0.
REQ-028 Valid window gives O_FREQ=10; next window has I_EN dropped at GATE cycle 50 -> no O_VALID, O_BUSY falls the next cycle, O_FREQ stays 10.
REQ-029 Rst pulsed at GATE cycle 40 -> all outputs 0 immediately; after release with I_EN=1 the first O_VALID arrives 101 cycles later with a full-window count.
REQ-030 Single I_SIG rising edge placed so its pulse lands on the last GATE cycle -> counted (O_FREQ=1); the same edge one cycle later -> not counted (O_FREQ=0).
